// File: rtl/sipo_rx_if.sv
// Handshake bundle for the serial-in/parallel-out receiver.
// parity_err exists only when SIPO_PARITY_EN is defined.
interface sipo_rx_if #(
  parameter int WIDTH = 8
);
  logic             ser_in;
  logic             ser_valid;
  logic             ser_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
`ifdef SIPO_PARITY_EN
  logic             parity_err;
`endif

  modport slave (
    input  ser_in, ser_valid, out_ready,
    output ser_ready, out_data, out_valid
`ifdef SIPO_PARITY_EN
    , output parity_err
`endif
  );

  modport master (
    output ser_in, ser_valid, out_ready,
    input  ser_ready, out_data, out_valid
`ifdef SIPO_PARITY_EN
    , input parity_err
`endif
  );
endinterface

// File: rtl/sipo_rx.sv
// Serial-in/parallel-out receiver with a one-word valid/ready output buffer.
// Optional even-parity bit per frame when SIPO_PARITY_EN is defined.
//
// state   | meaning
// COLLECT | accepting serial bits (ser_ready=1)
// STALL   | complete word parked in sr, buffer full (ser_ready=0)
module sipo_rx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic      clk,
  input logic      reset,
  sipo_rx_if.slave bus
);
`ifdef SIPO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(FRAME + 1);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] STALL   = 1'b1;

  logic [0:0]       state;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_shift;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             last_bit;
  logic             buf_free;
  logic             take_bit;

  always_comb begin
    sr_shift = sr;
    if (MSB_FIRST) sr_shift = {sr[WIDTH-2:0], bus.ser_in};
    else           sr_shift = {bus.ser_in, sr[WIDTH-1:1]};
  end

  // With parity the final bit is the parity bit, so the word is already complete in sr.
`ifdef SIPO_PARITY_EN
  assign word = sr;
`else
  assign word = sr_shift;
`endif

  assign last_bit = (bit_cnt == CW'(FRAME - 1));
  assign buf_free = !valid_q || bus.out_ready;
  assign take_bit = (state == COLLECT) && bus.ser_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= COLLECT;
      bit_cnt <= '0;
      sr      <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (valid_q && bus.out_ready) valid_q <= 1'b0;
      case (state)
        COLLECT: begin
          if (bus.ser_valid) begin
            if (last_bit) begin
              bit_cnt <= '0;
              if (buf_free) begin
                data_q  <= word;
                valid_q <= 1'b1;
              end else begin
                sr    <= word;
                state <= STALL;
              end
            end else begin
              sr      <= sr_shift;
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
        end
        STALL: begin
          if (bus.out_ready) begin
            data_q  <= sr;
            valid_q <= 1'b1;
            state   <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

`ifdef SIPO_PARITY_EN
  logic perr_q;
  logic perr_sr;

  always_ff @(posedge clk) begin
    if (reset) begin
      perr_q  <= 1'b0;
      perr_sr <= 1'b0;
    end else if (take_bit && last_bit) begin
      if (buf_free) perr_q  <= ^{sr, bus.ser_in};
      else          perr_sr <= ^{sr, bus.ser_in};
    end else if (state == STALL && bus.out_ready) begin
      perr_q <= perr_sr;
    end
  end

  assign bus.parity_err = perr_q;
`endif

  assign bus.ser_ready = (state == COLLECT);
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
endmodule
